mult_product_accumulator: RTL and testbench
===========================================

MULT_PRODUCT_ACCUMULATOR -- requirements
Module: mult_product_accumulator

Interface
REQ-001 Parameter W, default 16: width of each incoming product, equal to the multiplier's m+n output.
REQ-002 Parameter CNT, default 4, legal range 1..15: number of products that make up one accumulation frame.
REQ-003 Parameter ACC_W, default 18: accumulator and result width; legal range ACC_W >= W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  product on in_data is valid.
REQ-007 in_ready  output  1  block can accept a product this cycle.
REQ-008 in_data  input  W  unsigned product from the multiplier.
REQ-009 flush  input  1  close the current frame early.
REQ-010 out_valid  output  1  frame result is valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  ACC_W  frame sum, modulo 2^ACC_W.
REQ-013 out_count  output  4  number of products summed into out_data.
REQ-014 out_ovf  output  1  sticky: frame sum exceeded 2^ACC_W-1.

Function
REQ-015 Two states SHALL exist:
- ACCUM: collecting products.
- DONE: holding the result.
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A product SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-018 On accept, the block SHALL perform, all at the same edge:
- acc <= (acc + zero-extended in_data) mod 2^ACC_W;
- count <= count+1;
- ovf <= ovf OR carry-out of that addition.
REQ-019 ACCUM SHALL go to DONE at the edge where the accepted product makes count equal CNT; out_valid SHALL rise the next cycle, so latency from the last accept to out_valid is 1 cycle.
REQ-020 flush=1 in ACCUM SHALL go to DONE at that edge when (count>0) or (in_valid=1), and it SHALL include any product accepted in the same cycle.
REQ-021 flush=1 in ACCUM with count=0 and in_valid=0 SHALL be ignored.
REQ-022 flush in DONE SHALL be ignored.
REQ-023 In DONE, the following SHALL be held stable until the handshake: out_data=acc, out_count=count, out_ovf=ovf.
REQ-024 A DONE cycle with out_ready=1 SHALL at that edge:
- clear acc, count and ovf;
- return to ACCUM.
No product SHALL be accepted in that same cycle, since in_ready=0.
REQ-025 When ACC_W >= W + ceil(log2(CNT+1)), out_ovf SHALL never assert.
REQ-026 in_valid, in_data and flush SHALL be ignored when not in ACCUM.

Reset
REQ-027 When rst=0 at a rising edge, the block SHALL:
- enter ACCUM;
- clear acc, count and ovf.
REQ-028 While in reset, the outputs SHALL be:
- in_ready=1;
- out_valid=0;
- out_data=0;
- out_count=0;
- out_ovf=0.
REQ-029 Reset mid-frame or in DONE SHALL discard partial sums and pending results, with no out_valid emitted for them.
REQ-030 in_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-031 Defaults; products 10, 20, 30, 40 on 4 consecutive cycles; out_ready=1 -> out_valid one cycle after the 40 is accepted, with out_data=100, out_count=4, out_ovf=0; in_ready=1 again the following cycle.
REQ-032 Defaults; 2 products 0xFFFF, 0x0001, then flush=1 alone -> out_data=0x10000, out_count=2; a flush with count=0 and in_valid=0 produces no out_valid.
REQ-033 Defaults; last product accepted while out_ready=0 for 5 cycles -> out_valid, out_data and out_count stay constant and in_ready=0 throughout; in_valid pulses during DONE do not change the sum.
REQ-034 ACC_W=16, CNT=2; products 0xFFFF, 0x0002 -> out_data=0x0001, out_ovf=1; the next frame 1, 1 -> out_data=2, out_ovf=0.
REQ-035 Defaults; rst=0 asserted after 3 accepts, then released; frame 5, 5, 5, 5 -> out_data=20, out_count=4, with no earlier out_valid.
REQ-036 Defaults; flush=1 together with in_valid=1 and in_data=7 at count=1 (previous product 3) -> out_data=10, out_count=2.

Source files
------------

// File: rtl/mult_product_accumulator_if.sv
// mult_product_accumulator_if: product input stream, flush and result handshake bundle
//   master: drives in_valid/in_data/flush/out_ready, observes in_ready and the result
//   slave : the accumulator side of the same signals
interface mult_product_accumulator_if #(
    parameter int W     = 16,
    parameter int ACC_W = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [3:0]       out_count;
    logic             out_ovf;
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums CNT unsigned products (or fewer on flush) into one held frame result
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : slave side of mult_product_accumulator_if (product stream in, frame result out)
module mult_product_accumulator #(
    parameter int W     = 16,
    parameter int CNT   = 4,
    parameter int ACC_W = 18
) (
    input logic clk,
    input logic rst,
    mult_product_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [3:0]       r_count;
    logic             r_ovf;
    logic             w_accept;
    logic             w_close;
    logic [ACC_W:0]   w_sum;
    logic [3:0]       w_count_nxt;
    assign w_accept    = bus.in_valid && r_state == ACCUM;
    assign w_sum       = {1'b0, r_acc} + {{(ACC_W + 1 - W){1'b0}}, bus.in_data};
    assign w_count_nxt = r_count + 4'd1;
    // flush on an empty frame with nothing arriving is a no-op
    assign w_close     = (w_accept && w_count_nxt == 4'(CNT)) ||
                         (bus.flush && (r_count != 4'd0 || bus.in_valid));
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ACCUM;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == ACCUM) ? (w_close ? DONE : ACCUM) : (bus.out_ready ? ACCUM : DONE);
    end
    always_ff @(posedge clk) begin
        if (!rst || (r_state == DONE && bus.out_ready)) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | w_sum[ACC_W];
        end
    end
    // outputs are forced to their idle values while reset is held, before the first edge
    always_comb begin
        bus.in_ready  = !rst || r_state == ACCUM;
        bus.out_valid = rst && r_state == DONE;
        bus.out_data  = rst ? r_acc : '0;
        bus.out_count = rst ? r_count : 4'd0;
        bus.out_ovf   = rst && r_ovf;
    end
endmodule

// File: tb/tb_mult_product_accumulator.sv
// tb_mult_product_accumulator: directed vector table plus hand sequences for reset and overflow
module tb_mult_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    mult_product_accumulator_if #(.W(16), .ACC_W(18)) a_if ();
    mult_product_accumulator_if #(.W(16), .ACC_W(16)) b_if ();
    mult_product_accumulator dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mult_product_accumulator #(.W(16), .CNT(2), .ACC_W(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [17:0] e_data;
        logic [3:0]  e_cnt;
        logic        e_ovf;
    } vec_t;
    vec_t vq[$];
    int errs = 0;
    int checks = 0;
    function automatic void add(logic iv, logic [15:0] d, logic fl, logic ordy,
                                logic e_ir, logic e_ov, logic [17:0] e_data, logic [3:0] e_cnt, logic e_ovf);
        vec_t v;
        v = '{iv, d, fl, ordy, e_ir, e_ov, e_data, e_cnt, e_ovf};
        vq.push_back(v);
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive_a(logic iv, logic [15:0] d, logic fl, logic ordy);
        a_if.in_valid  = iv;
        a_if.in_data   = d;
        a_if.flush     = fl;
        a_if.out_ready = ordy;
    endtask
    task automatic drive_b(logic iv, logic [15:0] d, logic ordy);
        b_if.in_valid  = iv;
        b_if.in_data   = d;
        b_if.flush     = 1'b0;
        b_if.out_ready = ordy;
    endtask
    initial begin
        // full frame 10,20,30,40
        add(1, 16'd10, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd20, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd30, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd40, 0, 1, 1, 0, 0, 0, 0);
        add(0, 16'd0,  0, 1, 0, 1, 18'd100, 4'd4, 0);
        // two products then a lone flush, then an ignored empty flush
        add(1, 16'hFFFF, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0001, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'd0,    1, 0, 1, 0, 0, 0, 0);
        add(0, 16'd0,    0, 1, 0, 1, 18'h10000, 4'd2, 0);
        add(0, 16'd0,    1, 0, 1, 0, 0, 0, 0);
        add(0, 16'd0,    0, 0, 1, 0, 0, 0, 0);
        add(0, 16'd0,    0, 0, 1, 0, 0, 0, 0);
        // result held 5 cycles under back-pressure with ignored inputs
        add(1, 16'd1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd2, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd3, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd4, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h1234, 0, 0, 0, 1, 18'd10, 4'd4, 0);
        add(0, 16'd0,    1, 0, 0, 1, 18'd10, 4'd4, 0);
        add(1, 16'hFFFF, 1, 0, 0, 1, 18'd10, 4'd4, 0);
        add(1, 16'd5,    0, 0, 0, 1, 18'd10, 4'd4, 0);
        add(0, 16'd0,    0, 1, 0, 1, 18'd10, 4'd4, 0);
        // flush together with a product at count=1
        add(1, 16'd3, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'd7, 1, 0, 1, 0, 0, 0, 0);
        add(0, 16'd0, 0, 1, 0, 1, 18'd10, 4'd2, 0);
        add(0, 16'd0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(a_if.in_ready), 32'd1);
        chk("rst out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst out_data", 32'(a_if.out_data), 32'd0);
        chk("rst out_count", 32'(a_if.out_count), 32'd0);
        chk("rst out_ovf", 32'(a_if.out_ovf), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), 32'(a_if.in_ready), 32'(vq[i].e_ir));
            chk($sformatf("v%0d out_valid", i), 32'(a_if.out_valid), 32'(vq[i].e_ov));
            if (vq[i].e_ov) begin
                chk($sformatf("v%0d out_data", i), 32'(a_if.out_data), 32'(vq[i].e_data));
                chk($sformatf("v%0d out_count", i), 32'(a_if.out_count), 32'(vq[i].e_cnt));
                chk($sformatf("v%0d out_ovf", i), 32'(a_if.out_ovf), 32'(vq[i].e_ovf));
            end
            drive_a(vq[i].iv, vq[i].d, vq[i].fl, vq[i].ordy);
        end
        // reset mid-frame discards the partial sum
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_a(1, 16'd5, 0, 0);
        end
        @(negedge clk);
        drive_a(0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst in_ready", 32'(a_if.in_ready), 32'd1);
        chk("midrst out_valid", 32'(a_if.out_valid), 32'd0);
        chk("midrst out_data", 32'(a_if.out_data), 32'd0);
        chk("midrst out_count", 32'(a_if.out_count), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst %0d out_valid", k), 32'(a_if.out_valid), 32'd0);
            chk($sformatf("post-rst %0d in_ready", k), 32'(a_if.in_ready), 32'd1);
            drive_a(1, 16'd5, 0, 0);
        end
        @(negedge clk);
        drive_a(0, 0, 0, 0);
        chk("post-rst out_valid", 32'(a_if.out_valid), 32'd1);
        chk("post-rst out_data", 32'(a_if.out_data), 32'd20);
        chk("post-rst out_count", 32'(a_if.out_count), 32'd4);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b0;
        chk("post-rst release in_ready", 32'(a_if.in_ready), 32'd1);
        // narrow accumulator: overflow is sticky within a frame and cleared between frames
        drive_b(1, 16'hFFFF, 0);
        @(negedge clk);
        drive_b(1, 16'h0002, 0);
        @(negedge clk);
        drive_b(0, 0, 0);
        chk("ovf out_valid", 32'(b_if.out_valid), 32'd1);
        chk("ovf out_data", 32'(b_if.out_data), 32'h1);
        chk("ovf out_count", 32'(b_if.out_count), 32'd2);
        chk("ovf out_ovf", 32'(b_if.out_ovf), 32'd1);
        b_if.out_ready = 1'b1;
        @(negedge clk);
        chk("ovf release in_ready", 32'(b_if.in_ready), 32'd1);
        drive_b(1, 16'd1, 0);
        @(negedge clk);
        drive_b(1, 16'd1, 0);
        @(negedge clk);
        drive_b(0, 0, 0);
        chk("ovf2 out_valid", 32'(b_if.out_valid), 32'd1);
        chk("ovf2 out_data", 32'(b_if.out_data), 32'd2);
        chk("ovf2 out_ovf", 32'(b_if.out_ovf), 32'd0);
        b_if.out_ready = 1'b1;
        @(negedge clk);
        b_if.out_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
